// File: rtl/peripherals_pkg.sv
// peripherals_pkg -- shared constants and types for the peripherals_mc block.
//   Register byte offsets, channel strides, PWM period and the per-timer
//   write request struct handed from the top-level decoder to periph_timer.
package peripherals_pkg;

  // Register byte offsets
  localparam logic [31:0] ADDR_DIN        = 32'h00;
  localparam logic [31:0] ADDR_DOUT       = 32'h04;
  localparam logic [31:0] ADDR_IRQ_STATUS = 32'h08;
  localparam logic [31:0] ADDR_IRQ_ENABLE = 32'h0C;
  localparam logic [31:0] ADDR_TIMER_BASE = 32'h20;
  localparam logic [31:0] ADDR_PWM_BASE   = 32'h60;

  // Channel strides and hard channel limits (address windows are sized for 4)
  localparam int TIMER_STRIDE = 16;
  localparam int PWM_STRIDE   = 4;
  localparam int MAX_TIMERS   = 4;
  localparam int MAX_PWM      = 4;

  localparam int PWM_PERIOD = 100;
  localparam int DUTY_W     = 7;   // holds 0..100

  // Word slot inside one timer's 16-byte window
  typedef enum logic [1:0] {
    TREG_PRESC = 2'd0,
    TREG_COUNT = 2'd1,
    TREG_CMP   = 2'd2,
    TREG_RSVD  = 2'd3
  } timer_reg_e;

  typedef struct packed {
    logic        presc_we;
    logic        count_we;
    logic        cmp_we;
    logic [31:0] wdata;
  } timer_wr_t;

  // Duty writes above one full period clamp to always-high
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [31:0] v);
    return (v > 32'(PWM_PERIOD)) ? DUTY_W'(PWM_PERIOD) : v[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/periph_timer.sv
// periph_timer -- one timer channel: prescaler, 32-bit counter, compare.
//   clk, rst  : clock, synchronous active-high reset
//   wr_i      : decoded register writes for this channel
//   presc_o / count_o / cmp_o : register values for readback
//   match_o   : one-cycle pulse, high in the cycle whose closing edge
//               returns COUNT to 0 on a compare match
module periph_timer
  import peripherals_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  timer_wr_t   wr_i,
  output logic [31:0] presc_o,
  output logic [31:0] count_o,
  output logic [31:0] cmp_o,
  output logic        match_o
);

  logic [31:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q,   cmp_d;
  logic [31:0] pc_q,    pc_d;     // prescaler phase, 0..PRESC-1
  logic        tick;

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    pc_d    = pc_q;
    match_o = 1'b0;

    // PRESC=0 parks the channel; otherwise tick on the last prescaler phase
    tick = (presc_q != '0) && (pc_q == presc_q - 32'd1);

    if (presc_q != '0) pc_d = tick ? '0 : pc_q + 32'd1;

    if (tick) begin
      if ((cmp_q != '0) && (count_q == cmp_q)) begin
        count_d = '0;
        match_o = 1'b1;
      end else begin
        count_d = count_q + 32'd1;   // CMP=0 free-runs and wraps silently
      end
    end

    if (wr_i.cmp_we) cmp_d = wr_i.wdata;

    // A COUNT or PRESC write discards any coincident tick and its match
    if (wr_i.presc_we || wr_i.count_we) begin
      pc_d    = '0;
      match_o = 1'b0;
      count_d = wr_i.count_we ? wr_i.wdata : count_q;
    end
    if (wr_i.presc_we) presc_d = wr_i.wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      pc_q    <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      pc_q    <= pc_d;
    end
  end

  assign presc_o = presc_q;
  assign count_o = count_q;
  assign cmp_o   = cmp_q;

endmodule

// File: rtl/peripherals_mc.sv
// peripherals_mc -- memory-mapped microcontroller peripherals.
//   clk, rst      : clock, synchronous active-high reset
//   A, WD, WE     : byte address (A[1:0] ignored), write data, write strobe
//   RD            : read data, registered (one cycle after A)
//   sw, btn, ipin : asynchronous inputs, two-flop synchronized into DIN
//   dout          : DOUT register low bits
//   pwm           : N_PWM outputs, 100-cycle period, shadowed duty
//   irq           : registered OR of enabled timer match flags
module peripherals_mc
  import peripherals_pkg::*;
#(
  parameter int AW        = 8,
  parameter int N_TIMERS  = 2,
  parameter int N_PWM     = 2,
  parameter int N_OUTPUTS = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        A,
  input  logic [31:0]          WD,
  input  logic                 WE,
  output logic [31:0]          RD,
  input  logic [15:0]          sw,
  input  logic [4:0]           btn,
  input  logic [3:0]           ipin,
  output logic [N_OUTPUTS-1:0] dout,
  output logic [N_PWM-1:0]     pwm,
  output logic                 irq
);

  // ---------------- address decode ----------------
  logic [31:0] addr_w, t_off, p_off;
  logic        in_timer, in_pwm;
  logic [1:0]  t_idx, p_idx;
  timer_reg_e  t_reg;
  logic        unused_a;

  assign unused_a = ^A[1:0];
  assign addr_w   = 32'({A[AW-1:2], 2'b00});
  assign t_off    = addr_w - ADDR_TIMER_BASE;
  assign p_off    = addr_w - ADDR_PWM_BASE;
  assign in_timer = (addr_w >= ADDR_TIMER_BASE) &&
                    (addr_w <  ADDR_TIMER_BASE + 32'(MAX_TIMERS * TIMER_STRIDE));
  assign in_pwm   = (addr_w >= ADDR_PWM_BASE) &&
                    (addr_w <  ADDR_PWM_BASE + 32'(MAX_PWM * PWM_STRIDE));
  assign t_idx    = 2'(t_off >> $clog2(TIMER_STRIDE));
  assign t_reg    = timer_reg_e'(2'(t_off >> 2));
  assign p_idx    = 2'(p_off >> $clog2(PWM_STRIDE));

  // ---------------- state ----------------
  logic [24:0]                     din_meta_q, din_meta_d;
  logic [24:0]                     din_sync_q, din_sync_d;
  logic [N_OUTPUTS-1:0]            dout_q, dout_d;
  logic [N_TIMERS-1:0]             stat_q, stat_d;
  logic [N_TIMERS-1:0]             ien_q, ien_d;
  logic                            irq_q, irq_d;
  logic [31:0]                     rd_q, rd_d;
  logic [DUTY_W-1:0]               phase_q, phase_d;
  logic [N_PWM-1:0][DUTY_W-1:0]    shadow_q, shadow_d;
  logic [N_PWM-1:0][DUTY_W-1:0]    duty_q, duty_d;

  // ---------------- timers ----------------
  timer_wr_t [N_TIMERS-1:0]        tw;
  logic [N_TIMERS-1:0][31:0]       t_presc, t_count, t_cmp;
  logic [N_TIMERS-1:0]             t_match;

  always_comb begin
    tw = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      tw[i].wdata = WD;
      if (WE && in_timer && (t_idx == 2'(i))) begin
        tw[i].presc_we = (t_reg == TREG_PRESC);
        tw[i].count_we = (t_reg == TREG_COUNT);
        tw[i].cmp_we   = (t_reg == TREG_CMP);
      end
    end
  end

  for (genvar i = 0; i < N_TIMERS; i++) begin : g_tmr
    periph_timer u_tmr (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (tw[i]),
      .presc_o (t_presc[i]),
      .count_o (t_count[i]),
      .cmp_o   (t_cmp[i]),
      .match_o (t_match[i])
    );
  end

  // ---------------- next-state ----------------
  always_comb begin
    din_meta_d = {ipin, btn, sw};
    din_sync_d = din_meta_q;

    dout_d = dout_q;
    if (WE && (addr_w == ADDR_DOUT)) dout_d = WD[N_OUTPUTS-1:0];

    ien_d = ien_q;
    if (WE && (addr_w == ADDR_IRQ_ENABLE)) ien_d = WD[N_TIMERS-1:0];

    // W1C first, then OR in new matches so a coincident set wins
    stat_d = stat_q;
    if (WE && (addr_w == ADDR_IRQ_STATUS)) stat_d = stat_q & ~WD[N_TIMERS-1:0];
    stat_d = stat_d | t_match;

    irq_d = |(stat_q & ien_q);

    phase_d = (phase_q == DUTY_W'(PWM_PERIOD - 1)) ? '0 : phase_q + 1'b1;

    shadow_d = shadow_q;
    duty_d   = duty_q;
    for (int i = 0; i < N_PWM; i++) begin
      if (WE && in_pwm && (p_idx == 2'(i))) shadow_d[i] = sat_duty(WD);
      // Latch the shadow only at the period boundary so periods stay whole
      if (phase_q == DUTY_W'(PWM_PERIOD - 1)) duty_d[i] = shadow_d[i];
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    rd_d = '0;
    if (addr_w == ADDR_DIN)             rd_d = 32'(din_sync_q);
    else if (addr_w == ADDR_DOUT)       rd_d = 32'(dout_q);
    else if (addr_w == ADDR_IRQ_STATUS) rd_d = 32'(stat_q);
    else if (addr_w == ADDR_IRQ_ENABLE) rd_d = 32'(ien_q);
    else if (in_timer) begin
      for (int i = 0; i < N_TIMERS; i++) begin
        if (t_idx == 2'(i)) begin
          case (t_reg)
            TREG_PRESC: rd_d = t_presc[i];
            TREG_COUNT: rd_d = t_count[i];
            TREG_CMP:   rd_d = t_cmp[i];
            default:    rd_d = '0;
          endcase
        end
      end
    end else if (in_pwm) begin
      for (int i = 0; i < N_PWM; i++) begin
        if (p_idx == 2'(i)) rd_d = 32'(shadow_q[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_meta_q <= '0;
      din_sync_q <= '0;
      dout_q     <= '0;
      stat_q     <= '0;
      ien_q      <= '0;
      irq_q      <= 1'b0;
      rd_q       <= '0;
      phase_q    <= '0;
      shadow_q   <= '0;
      duty_q     <= '0;
    end else begin
      din_meta_q <= din_meta_d;
      din_sync_q <= din_sync_d;
      dout_q     <= dout_d;
      stat_q     <= stat_d;
      ien_q      <= ien_d;
      irq_q      <= irq_d;
      rd_q       <= rd_d;
      phase_q    <= phase_d;
      shadow_q   <= shadow_d;
      duty_q     <= duty_d;
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < N_PWM; i++) pwm[i] = (phase_q < duty_q[i]);
  end

  assign RD   = rd_q;
  assign dout = dout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_peripherals_mc.sv
module tb_peripherals_mc;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] A;
  logic [31:0]   WD;
  logic          WE;
  logic [31:0]   RD;
  logic [15:0]   sw;
  logic [4:0]    btn;
  logic [3:0]    ipin;
  logic [19:0]   dout;
  logic [1:0]    pwm;
  logic          irq;

  int checks = 0;
  int errors = 0;

  peripherals_mc #(.AW(AW), .N_TIMERS(2), .N_PWM(2), .N_OUTPUTS(20)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .RD(RD),
    .sw(sw), .btn(btn), .ipin(ipin), .dout(dout), .pwm(pwm), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge
  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    A = a; WD = d; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
    A = a; WE = 1'b0;
    @(negedge clk);
    d = RD;
  endtask

  initial begin
    logic [31:0] v;
    logic        prev, found;
    int          hi1, hi2, cnt;

    rst = 1'b1; A = '0; WD = '0; WE = 1'b0; sw = '0; btn = '0; ipin = '0;
    repeat (3) @(negedge clk);
    check("reset_rd",   RD,   32'h0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_pwm",  32'(pwm),  32'h0);
    check("reset_irq",  32'(irq),  32'h0);
    rst = 1'b0;
    rd(8'h0C, v); check("ien_reset", v, 32'h0);

    // DIN through the two-flop synchronizer
    sw = 16'hA5A5;
    rd(8'h00, v); check("din_lat0", v, 32'h0);
    rd(8'h00, v); check("din_lat1", v, 32'h0);
    rd(8'h00, v); check("din_lat2", v, 32'h0000A5A5);
    btn = 5'h13; ipin = 4'hC;
    repeat (2) @(negedge clk);
    rd(8'h00, v); check("din_all", v, 32'h0193A5A5);
    wr(8'h00, 32'hDEADBEEF);
    rd(8'h00, v); check("din_ro", v, 32'h0193A5A5);

    // DOUT width masking and ignored low address bits
    wr(8'h04, 32'hFFFFFFFF);
    check("dout_pin", 32'(dout), 32'h000FFFFF);
    rd(8'h04, v); check("dout_rd", v, 32'h000FFFFF);
    rd(8'h07, v); check("dout_rd_a10", v, 32'h000FFFFF);

    // Unmapped / absent channels
    wr(8'h40, 32'h1234);
    rd(8'h40, v); check("absent_timer2", v, 32'h0);
    rd(8'h10, v); check("unmapped_10", v, 32'h0);
    rd(8'h2C, v); check("timer_rsvd", v, 32'h0);
    wr(8'h68, 32'd50);
    rd(8'h68, v); check("absent_pwm2", v, 32'h0);

    // Timer0: PRESC=2, CMP=3 -> match 8 cycles after the PRESC write
    wr(8'h28, 32'd3);
    rd(8'h28, v); check("cmp0_rd", v, 32'd3);
    wr(8'h0C, 32'h1);
    rd(8'h0C, v); check("ien_rd", v, 32'h1);
    wr(8'h20, 32'd2);                           // k=0
    repeat (7) @(negedge clk);                  // k=7
    check("irq_k7", 32'(irq), 32'h0);
    rd(8'h08, v); check("stat_k7", v, 32'h0);   // now k=8
    check("irq_k8", 32'(irq), 32'h0);
    rd(8'h08, v); check("stat_k8", v, 32'h1);   // now k=9
    check("irq_k9", 32'(irq), 32'h1);

    // W1C, then W1C colliding with the next match at k=16
    wr(8'h08, 32'h1);                           // k=10
    rd(8'h08, v); check("stat_w1c", v, 32'h0);  // k=11
    check("irq_w1c", 32'(irq), 32'h0);
    repeat (4) @(negedge clk);                  // k=15
    wr(8'h08, 32'h1);                           // k=16, match edge
    rd(8'h08, v); check("stat_set_wins", v, 32'h1);
    check("irq_set_wins", 32'(irq), 32'h1);

    // Timer1 CMP=0 wrap without a flag
    wr(8'h34, 32'hFFFFFFFE);
    wr(8'h30, 32'd1);
    rd(8'h34, v); check("cnt1_fe", v, 32'hFFFFFFFE);
    rd(8'h34, v); check("cnt1_ff", v, 32'hFFFFFFFF);
    rd(8'h34, v); check("cnt1_wrap", v, 32'h0);
    rd(8'h08, v); check("stat_no_t1", v, 32'h1);
    wr(8'h30, 32'd0);
    wr(8'h34, 32'd5);
    repeat (3) @(negedge clk);
    rd(8'h34, v); check("cnt1_hold5", v, 32'd5);

    // PWM0: duty 30, then 70 written at phase 50
    wr(8'h60, 32'd30);
    prev = pwm[0]; found = 1'b0;
    for (int t = 0; t < 250 && !found; t++) begin
      @(negedge clk);
      if (!prev && pwm[0]) found = 1'b1;
      prev = pwm[0];
    end
    check("pwm0_rise", 32'(found), 32'h1);
    hi1 = 0; hi2 = 0;
    for (int c = 0; c < 200; c++) begin
      if (pwm[0]) begin
        if (c < 100) hi1++; else hi2++;
      end
      if (c == 50) begin A = 8'h60; WD = 32'd70; WE = 1'b1; end
      @(negedge clk);
      WE = 1'b0;
    end
    check("pwm0_period1", 32'(hi1), 32'd30);
    check("pwm0_period2", 32'(hi2), 32'd70);
    rd(8'h60, v); check("pwm0_rd", v, 32'd70);

    // PWM1 saturation
    wr(8'h64, 32'd120);
    rd(8'h64, v); check("pwm1_sat_rd", v, 32'd100);
    repeat (101) @(negedge clk);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (!pwm[1]) cnt++;
      @(negedge clk);
    end
    check("pwm1_always_hi", 32'(cnt), 32'd0);

    // Reset mid-period, mid-count
    rd(8'h34, v); check("cnt1_pre_rst", v, 32'd5);
    check("irq_pre_rst", 32'(irq), 32'h1);
    check("pwm1_pre_rst", 32'(pwm[1]), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_pwm", 32'(pwm), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_rd", RD, 32'h0);
    rst = 1'b0;
    rd(8'h34, v); check("rst_cnt1", v, 32'h0);
    rd(8'h08, v); check("rst_stat", v, 32'h0);
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      if (pwm != 2'b00 || irq) cnt++;
      @(negedge clk);
    end
    check("rst_no_residual", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
